adc_dec_formatter: RTL and testbench
====================================

// Module: adc_dec_formatter
// PURPOSE
//   Buffers 16-bit ADC samples from the I2C ADC driver (o_data/o_valid/o_error)
//   and renders each one as a fixed-width signed decimal ASCII line,
//   e.g. "+12345\r\n".
//   Drives uart_tx through its tx_data/tx_start/tx_busy handshake.
//   Replaces the hex-only TX state machine in the ADC top level.
//   A small FIFO absorbs samples that arrive while a line is still in flight.
// PARAMETERS
//   FIFO_AW   2   FIFO address width; depth = 2**FIFO_AW samples
//   SIGNED    1   1: two's-complement input, sign char emitted; 0: unsigned, no sign char
// PORTS
//   clk            in   1          system clock
//   rst            in   1          asynchronous, active-high reset
//   i_data         in   16         ADC sample
//   i_valid        in   1          1-cycle strobe; i_data valid
//   i_error        in   1          ADC driver error level
//   i_tx_busy      in   1          uart_tx busy
//   o_tx_data      out  8          ASCII byte to uart_tx
//   o_tx_start     out  1          1-cycle start pulse to uart_tx
//   o_overflow     out  1          1-cycle pulse: sample dropped (FIFO full)
//   o_drop_cnt     out  8          saturating count of dropped samples
//   o_fifo_level   out  FIFO_AW+1  samples currently queued
// BEHAVIOUR
//   Reset:
//   - All outputs 0, FIFO empty, err_pending 0, FSM IDLE.
//   - Async reset aborts any partial line; o_tx_start drops immediately.
//   FIFO write:
//   - On i_valid, write if level < DEPTH, or if a pop occurs in the same cycle.
//   - Otherwise drop the sample, pulse o_overflow, and increment o_drop_cnt (holds at 255).
//   Error:
//   - A rising edge of i_error sets err_pending.
//   - An edge while already pending is a no-op.
//   - err_pending is served only at a line boundary (IDLE) and wins over the FIFO.
//   - Error line is "E\r\n"; err_pending clears when the 'E' byte is issued.
//   FSM states: IDLE, POP, CONV, SEND_SIGN, SEND_DIG, SEND_CR, SEND_LF, SEND_ERR.
//   - IDLE -> SEND_ERR if err_pending; else -> POP if level>0.
//   - POP: read head. mag[16:0] = (SIGNED && d[15]) ? -{d[15],d} : {1'b0,d}, so 0x8000 -> 32768.
//     Latch sign.
//   - CONV: one compare per cycle, place p=0..3 with weights 10000/1000/100/10.
//     - If rem >= W[p]: rem -= W[p] and dig[p]++.
//     - Else: p++.
//     - After p=3, dig[4] = rem and go to SEND_SIGN (SIGNED=1) or SEND_DIG (SIGNED=0).
//     - Worst case 6+9+9+9+4 cycles.
//   - SEND_SIGN: '-' if negative, else '+'.
//   - SEND_DIG: '0'+dig[k], k = 0..4.
//   - Then CR (0x0D), then LF (0x0A), then IDLE. SEND_ERR sends 'E', then CR, then LF.
//   - Leading zeros are always emitted: 8 chars/line when SIGNED=1, 7 when SIGNED=0.
//   TX handshake:
//   - Issue a byte only when !i_tx_busy && !o_tx_start.
//   - o_tx_data and the o_tx_start pulse update in the same cycle; o_tx_data holds until the next issue.
//   - uart_tx must raise busy the cycle after start.
//   - Byte-to-byte gap is therefore at least 2 cycles.
//   Line integrity:
//   - Lines are never interleaved or truncated except by reset.
//   - FIFO order is preserved.
// TESTING
//   1. SIGNED=1, i_data=0x3039 -> bytes "+12345\r\n"; o_fifo_level returns to 0.
//   2. 0x8000 -> "-32768\r\n"; 0xFFFF -> "-00001\r\n"; 0x0000 -> "+00000\r\n".
//      SIGNED=0 with 0xFFFF -> "65535\r\n".
//   3. i_tx_busy held 1; 6 back-to-back i_valid (0x0001..0x0006) -> level saturates at 4.
//      Expect 2 o_overflow pulses and o_drop_cnt=2.
//      After busy releases, lines "+00001".."+00004" (each ending \r\n) in order.
//   4. i_error rises during the 3rd digit of "+00100" -> that line completes unbroken.
//      Then "E\r\n", then the queued sample's line.
//      A second error edge while pending yields a single "E".
//   5. rst pulsed during SEND_DIG -> o_tx_start=0 and level=0 in the same cycle.
//      Next sample produces a complete 8-byte line.
//   6. 300 drops with busy stuck -> o_drop_cnt saturates at 255.
//      Pop and write in the same cycle while full -> sample accepted, no overflow pulse.

Source files
------------

// File: rtl/adc_dec_formatter.sv
// Buffers ADC samples in a small FIFO and renders each as a fixed-width decimal ASCII
// line ("+12345\r\n") through the uart_tx start/busy handshake. Error edges insert "E\r\n".
module adc_dec_formatter #(
    parameter int FIFO_AW = 2,
    parameter bit SIGNED  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        i_data,
    input  logic               i_valid,
    input  logic               i_error,
    input  logic               i_tx_busy,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    output logic               o_overflow,
    output logic [7:0]         o_drop_cnt,
    output logic [FIFO_AW:0]   o_fifo_level
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, POP, CONV, SEND_SIGN, SEND_DIG, SEND_CR, SEND_LF, SEND_ERR
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [15:0]          mem_r [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]     level_r;
    logic                 pop_s, push_s, drop_s;
    logic                 err_prev_r, err_pending_r;
    logic                 sign_r;
    logic [16:0]          rem_r, weight_s, mag_s;
    logic [3:0]           dig_r [5];
    logic [1:0]           p_r;
    logic [2:0]           k_r;
    logic                 can_issue_s, issue_s;
    logic [7:0]           byte_s;

    function automatic logic [16:0] place_weight(input logic [1:0] p);
        case (p)
            2'd0:    place_weight = 17'd10000;
            2'd1:    place_weight = 17'd1000;
            2'd2:    place_weight = 17'd100;
            default: place_weight = 17'd10;
        endcase
    endfunction

    assign pop_s        = (state_r == POP);
    assign push_s       = i_valid && ((level_r < DEPTH_L) || pop_s);
    assign drop_s       = i_valid && !push_s;
    assign weight_s     = place_weight(p_r);
    assign can_issue_s  = !i_tx_busy && !o_tx_start;
    assign o_fifo_level = level_r;
    // Negation in 17 bits so 0x8000 yields a magnitude of 32768.
    assign mag_s = (SIGNED && mem_r[rd_ptr_r][15]) ? (17'd0 - {mem_r[rd_ptr_r][15], mem_r[rd_ptr_r]})
                                                   : {1'b0, mem_r[rd_ptr_r]};

    // Sample storage; a write to a full FIFO is only allowed when the head is popped.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // FIFO pointers, level, overflow pulse and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            o_overflow <= 1'b0;
            o_drop_cnt <= 8'd0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
            o_overflow <= drop_s;
            if (drop_s && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end

    // Error edge capture; pending clears when the 'E' byte goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_prev_r    <= 1'b0;
            err_pending_r <= 1'b0;
        end else begin
            err_prev_r <= i_error;
            if (state_r == SEND_ERR && issue_s) begin
                err_pending_r <= 1'b0;
            end else if (i_error && !err_prev_r) begin
                err_pending_r <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_nxt_s;
    end

    // Next-state and byte-issue decode.
    always_comb begin
        state_nxt_s = state_r;
        issue_s     = 1'b0;
        byte_s      = 8'h00;
        case (state_r)
            IDLE: begin
                if (err_pending_r)          state_nxt_s = SEND_ERR;
                else if (level_r != '0)     state_nxt_s = POP;
                else                        state_nxt_s = IDLE;
            end
            POP: state_nxt_s = CONV;
            CONV: begin
                if ((p_r == 2'd3) && (rem_r < weight_s)) state_nxt_s = SIGNED ? SEND_SIGN : SEND_DIG;
                else                                     state_nxt_s = CONV;
            end
            SEND_SIGN: begin
                if (can_issue_s) begin
                    issue_s     = 1'b1;
                    byte_s      = sign_r ? 8'h2D : 8'h2B;
                    state_nxt_s = SEND_DIG;
                end else begin
                    state_nxt_s = SEND_SIGN;
                end
            end
            SEND_DIG: begin
                if (can_issue_s) begin
                    issue_s     = 1'b1;
                    byte_s      = 8'h30 + {4'h0, dig_r[k_r]};
                    state_nxt_s = (k_r == 3'd4) ? SEND_CR : SEND_DIG;
                end else begin
                    state_nxt_s = SEND_DIG;
                end
            end
            SEND_CR: begin
                if (can_issue_s) begin
                    issue_s     = 1'b1;
                    byte_s      = 8'h0D;
                    state_nxt_s = SEND_LF;
                end else begin
                    state_nxt_s = SEND_CR;
                end
            end
            SEND_LF: begin
                if (can_issue_s) begin
                    issue_s     = 1'b1;
                    byte_s      = 8'h0A;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SEND_LF;
                end
            end
            SEND_ERR: begin
                if (can_issue_s) begin
                    issue_s     = 1'b1;
                    byte_s      = 8'h45;
                    state_nxt_s = SEND_CR;
                end else begin
                    state_nxt_s = SEND_ERR;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Conversion datapath: repeated subtraction per decimal place, then digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            rem_r  <= 17'd0;
            p_r    <= 2'd0;
            k_r    <= 3'd0;
            for (int i = 0; i < 5; i++) dig_r[i] <= 4'd0;
        end else begin
            case (state_r)
                POP: begin
                    sign_r <= SIGNED && mem_r[rd_ptr_r][15];
                    rem_r  <= mag_s;
                    p_r    <= 2'd0;
                    k_r    <= 3'd0;
                    for (int i = 0; i < 5; i++) dig_r[i] <= 4'd0;
                end
                CONV: begin
                    if (rem_r >= weight_s) begin
                        rem_r          <= rem_r - weight_s;
                        dig_r[{1'b0, p_r}] <= dig_r[{1'b0, p_r}] + 4'd1;
                    end else if (p_r == 2'd3) begin
                        dig_r[4] <= rem_r[3:0];
                    end else begin
                        p_r <= p_r + 2'd1;
                    end
                end
                SEND_DIG: begin
                    if (issue_s) k_r <= k_r + 3'd1;
                end
                default: k_r <= k_r;
            endcase
        end
    end

    // Registered TX outputs; data holds between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tx_start <= 1'b0;
            o_tx_data  <= 8'h00;
        end else begin
            o_tx_start <= issue_s;
            if (issue_s) o_tx_data <= byte_s;
        end
    end

endmodule

// File: tb/tb_adc_dec_formatter.sv
// Bench for adc_dec_formatter: signed and unsigned instances side by side, each with its
// own uart_tx busy responder, compared against lines rendered with plain integer formatting.
module tb_adc_dec_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] i_data = 16'h0000;
    logic        i_valid = 1'b0;
    logic        i_error = 1'b0;
    logic        tx_busy_s = 1'b0, tx_busy_u = 1'b0;
    logic [7:0]  tx_data_s, tx_data_u, drop_s, drop_u;
    logic        start_s, start_u, ovf_s, ovf_u;
    logic [2:0]  lvl_s, lvl_u;

    int total = 0;
    int bad = 0;
    byte unsigned rx_s[$], rx_u[$];
    string exp_s[$], exp_u[$];
    int cnt_s = 0, cnt_u = 0, ovf_cnt_s = 0, proto_err = 0, busy_len_fix = 0;
    bit busy_stuck = 1'b0;

    always #5 clk = ~clk;

    adc_dec_formatter #(.FIFO_AW(2), .SIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_error(i_error),
        .i_tx_busy(tx_busy_s), .o_tx_data(tx_data_s), .o_tx_start(start_s),
        .o_overflow(ovf_s), .o_drop_cnt(drop_s), .o_fifo_level(lvl_s));

    adc_dec_formatter #(.FIFO_AW(2), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid), .i_error(i_error),
        .i_tx_busy(tx_busy_u), .o_tx_data(tx_data_u), .o_tx_start(start_u),
        .o_overflow(ovf_u), .o_drop_cnt(drop_u), .o_fifo_level(lvl_u));

    // uart_tx stand-in: raises busy the cycle after each start, captures bytes
    always @(negedge clk) begin
        if (rst) begin
            cnt_s = 0; cnt_u = 0; tx_busy_s = 1'b0; tx_busy_u = 1'b0;
        end else begin
            if (start_s) begin
                if (tx_busy_s) proto_err++;
                rx_s.push_back(tx_data_s);
                cnt_s = (busy_len_fix != 0) ? busy_len_fix : $urandom_range(1, 4);
            end else if (cnt_s > 0) cnt_s--;
            if (start_u) begin
                if (tx_busy_u) proto_err++;
                rx_u.push_back(tx_data_u);
                cnt_u = (busy_len_fix != 0) ? busy_len_fix : $urandom_range(1, 4);
            end else if (cnt_u > 0) cnt_u--;
            tx_busy_s = busy_stuck || (cnt_s > 0);
            tx_busy_u = busy_stuck || (cnt_u > 0);
            if (ovf_s) ovf_cnt_s++;
        end
    end

    function automatic string line_signed(input logic [15:0] d);
        int v;
        v = $signed(d);
        if (v < 0) return $sformatf("-%05d\r\n", -v);
        else       return $sformatf("+%05d\r\n", v);
    endfunction

    function automatic string line_unsigned(input logic [15:0] d);
        int v;
        v = d;
        return $sformatf("%05d\r\n", v);
    endfunction

    function automatic string vis(input string s);
        string r;
        r = "";
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == 8'd13)      r = {r, "~"};
            else if (s[i] == 8'd10) r = {r, "|"};
            else                    r = $sformatf("%s%c", r, s[i]);
        end
        return r;
    endfunction

    task automatic push_exp(input logic [15:0] d);
        exp_s.push_back(line_signed(d));
        exp_u.push_back(line_unsigned(d));
    endtask

    task automatic send(input logic [15:0] d);
        i_data = d; i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    task automatic drain_check(input string name);
        string es, eu, gs, gu;
        int cyc;
        es = ""; eu = ""; gs = ""; gu = "";
        foreach (exp_s[i]) es = {es, exp_s[i]};
        foreach (exp_u[i]) eu = {eu, exp_u[i]};
        cyc = 0;
        while ((rx_s.size() < es.len() || rx_u.size() < eu.len()) && cyc < 4000) begin
            @(negedge clk); cyc++;
        end
        repeat (20) @(negedge clk);
        foreach (rx_s[i]) gs = $sformatf("%s%c", gs, rx_s[i]);
        foreach (rx_u[i]) gu = $sformatf("%s%c", gu, rx_u[i]);
        total++;
        if (gs != es) begin
            bad++; $display("FAIL %s signed: got \"%s\" want \"%s\"", name, vis(gs), vis(es));
        end
        total++;
        if (gu != eu) begin
            bad++; $display("FAIL %s unsigned: got \"%s\" want \"%s\"", name, vis(gu), vis(eu));
        end
        total++;
        if (proto_err != 0) begin
            bad++; $display("FAIL %s handshake: %0d starts while busy, want 0", name, proto_err);
        end
        exp_s.delete(); exp_u.delete(); rx_s.delete(); rx_u.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({start_s, ovf_s, drop_s, lvl_s, tx_data_s} !== 21'd0) begin
            bad++; $display("FAIL reset_signed: got %h want 0", {start_s, ovf_s, drop_s, lvl_s, tx_data_s});
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({start_u, ovf_u, drop_u, lvl_u, tx_data_u} !== 21'd0) begin
            bad++; $display("FAIL reset_unsigned: got %h want 0", {start_u, ovf_u, drop_u, lvl_u, tx_data_u});
        end
    endtask

    task automatic test_single();
        send(16'h3039); push_exp(16'h3039);
        drain_check("single");
        total++;
        if (lvl_s !== 3'd0) begin
            bad++; $display("FAIL single_level: got %0d want 0", lvl_s);
        end
    endtask

    task automatic test_corners();
        logic [15:0] v [5];
        v[0] = 16'h8000; v[1] = 16'hFFFF; v[2] = 16'h0000; v[3] = 16'h7FFF; v[4] = 16'h000A;
        foreach (v[i]) begin
            send(v[i]); push_exp(v[i]);
            drain_check($sformatf("corner_%h", v[i]));
        end
    endtask

    task automatic test_overflow();
        int base;
        busy_stuck = 1'b1;
        base = ovf_cnt_s;
        send(16'h0000); push_exp(16'h0000);
        repeat (20) @(negedge clk);
        for (int i = 1; i <= 6; i++) begin
            i_data = 16'(i); i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int i = 1; i <= 4; i++) push_exp(16'(i));
        repeat (2) @(negedge clk);
        total++;
        if (lvl_s !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", lvl_s); end
        total++;
        if (ovf_cnt_s - base != 2) begin bad++; $display("FAIL ovf_pulses: got %0d want 2", ovf_cnt_s - base); end
        total++;
        if (drop_s !== 8'd2 || drop_u !== 8'd2) begin
            bad++; $display("FAIL ovf_drop_cnt: got %0d/%0d want 2", drop_s, drop_u);
        end
        busy_stuck = 1'b0;
        drain_check("overflow");
    endtask

    task automatic test_error();
        int cyc;
        busy_len_fix = 2;
        send(16'h0064); send(16'h0007);
        exp_s.push_back(line_signed(16'h0064)); exp_u.push_back(line_unsigned(16'h0064));
        exp_s.push_back("E\r\n"); exp_u.push_back("E\r\n");
        push_exp(16'h0007);
        cyc = 0;
        while (rx_s.size() < 4 && cyc < 500) begin @(negedge clk); cyc++; end
        total++;
        if (rx_s.size() < 4) begin bad++; $display("FAIL error_wait: got %0d bytes want 4", rx_s.size()); end
        i_error = 1'b1; @(negedge clk);
        i_error = 1'b0; @(negedge clk);
        i_error = 1'b1;
        drain_check("error");
        i_error = 1'b0;
        busy_len_fix = 0;
    endtask

    task automatic test_reset_mid();
        int cyc;
        send(16'h1234); send(16'h0042);
        cyc = 0;
        while (rx_s.size() < 3 && cyc < 500) begin @(negedge clk); cyc++; end
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!start_s && cyc < 100);
        rst = 1'b1;
        #1;
        total++;
        if (start_s !== 1'b0 || lvl_s !== 3'd0 || start_u !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got start=%b level=%0d want start=0 level=0", start_s, lvl_s);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_s.delete(); exp_u.delete(); rx_s.delete(); rx_u.delete();
        @(negedge clk);
        total++;
        if (drop_s !== 8'd0) begin bad++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_s); end
        send(16'h0ABC); push_exp(16'h0ABC);
        drain_check("after_reset");
    endtask

    task automatic test_saturate();
        int base, n;
        bit accepted;
        busy_stuck = 1'b1;
        busy_len_fix = 2;
        send(16'h0000); push_exp(16'h0000);
        repeat (20) @(negedge clk);
        base = ovf_cnt_s;
        for (int i = 0; i < 304; i++) begin
            i_data = 16'h0100 + 16'(i); i_valid = 1'b1;
            @(negedge clk);
        end
        i_valid = 1'b0;
        for (int i = 0; i < 4; i++) push_exp(16'h0100 + 16'(i));
        repeat (2) @(negedge clk);
        total++;
        if (drop_s !== 8'd255 || drop_u !== 8'd255) begin
            bad++; $display("FAIL sat_drop_cnt: got %0d/%0d want 255", drop_s, drop_u);
        end
        total++;
        if (ovf_cnt_s - base != 300) begin bad++; $display("FAIL sat_pulses: got %0d want 300", ovf_cnt_s - base); end
        // keep offering one value until a pop lets it in
        base = ovf_cnt_s; n = 0; accepted = 1'b0;
        busy_stuck = 1'b0;
        i_data = 16'h0055;
        while (!accepted && n < 3000) begin
            i_valid = 1'b1;
            @(negedge clk); n++;
            if (!ovf_s) accepted = 1'b1;
        end
        i_valid = 1'b0;
        push_exp(16'h0055);
        total++;
        if (!accepted || lvl_s !== 3'd4) begin
            bad++; $display("FAIL pop_write: accepted=%b level=%0d want 1/4", accepted, lvl_s);
        end
        @(negedge clk);
        total++;
        if (ovf_cnt_s - base != n - 1) begin
            bad++; $display("FAIL pop_write_pulses: got %0d want %0d", ovf_cnt_s - base, n - 1);
        end
        drain_check("pop_write");
        busy_len_fix = 0;
    endtask

    task automatic test_random();
        int n;
        logic [15:0] d;
        for (int b = 0; b < 15; b++) begin
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                d = 16'($urandom);
                i_data = d; i_valid = 1'b1;
                push_exp(d);
                @(negedge clk);
            end
            i_valid = 1'b0;
            drain_check($sformatf("random_%0d", b));
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_corners();
        test_overflow();
        test_error();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
